// File: rtl/stream_out_port_if.sv
// stream_out_port_if: core data-bus + byte-stream bundle for stream_out_port.
//   Bus side   : address, wdata, enw (to responder), rdata (combinational back).
//   Stream side: out_data, out_valid (from block), out_ready (from sink).
// Modports: slave = the port block, master = core/sink side (bench).
interface stream_out_port_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wdata;
  logic             enw;
  logic [WIDTH-1:0] rdata;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  address, wdata, enw, out_ready,
    output rdata, out_data, out_valid
  );

  modport master (
    output address, wdata, enw, out_ready,
    input  rdata, out_data, out_valid
  );
endinterface

// File: rtl/stream_out_port.sv
// stream_out_port: memory-mapped word FIFO that serialises 32-bit words,
// LSB byte first, onto a valid/ready byte stream.
//   clock, reset : rising-edge clock, synchronous active-high reset.
//   bus (slave)  : address/wdata/enw write port, combinational rdata,
//                  out_data/out_valid/out_ready byte stream.
// Register window at BASE (16 bytes, address[1:0] ignored):
//   +0 DATA (write pushes), +4 STATUS, +8 CTRL (bit0 clear ovf, bit1 flush),
//   +12 drop counter when STREAM_OUT_DROPCNT_EN is defined, else reads 0.
// Optional feature macro: STREAM_OUT_DROPCNT_EN.
module stream_out_port #(
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'h1000_0000
) (
  input  logic            clock,
  input  logic            reset,
  stream_out_port_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  state_t           r_state;
  logic [31:0]      r_shreg;
  logic [1:0]       r_idx;

  logic w_hit, w_wr_data, w_wr_ctrl, w_full, w_empty;
  logic w_push, w_drop, w_flush, w_clr, w_last, w_pop, w_busy;
  logic [WIDTH-1:0] w_rdata;
  logic w_unused;

  assign w_hit     = (bus.address[WIDTH-1:4] == BASE[WIDTH-1:4]);
  assign w_wr_data = bus.enw & w_hit & (bus.address[3:2] == 2'd0);
  assign w_wr_ctrl = bus.enw & w_hit & (bus.address[3:2] == 2'd2);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a push.
  assign w_push    = w_wr_data & ~w_full;
  assign w_drop    = w_wr_data & w_full;
  assign w_flush   = w_wr_ctrl & bus.wdata[1];
  assign w_clr     = w_wr_ctrl & bus.wdata[0];
  assign w_last    = (r_state == S_SEND) & bus.out_ready & (r_idx == 2'd3);
  // Pop when idle, or back-to-back on the last byte; flush overrides it.
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | w_last) & ~w_flush;
  assign w_busy    = ~w_empty | (r_state != S_IDLE);
  assign w_unused  = ^bus.address[1:0];

  assign bus.out_valid = (r_state == S_SEND);
  assign bus.out_data  = r_shreg[{r_idx, 3'b000} +: 8];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= bus.wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
    end else begin
      if (w_clr)       r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;

      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);

        case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              r_shreg <= r_mem[r_rptr];
              r_idx   <= '0;
              r_state <= S_SEND;
            end
          end
          S_SEND: begin
            if (bus.out_ready) begin
              if (r_idx == 2'd3) begin
                r_idx <= '0;
                if (!w_empty) r_shreg <= r_mem[r_rptr];
                else          r_state <= S_IDLE;
              end else begin
                r_idx <= r_idx + 2'd1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef STREAM_OUT_DROPCNT_EN
  logic [15:0] r_dropcnt;

  always_ff @(posedge clock) begin
    if (reset || w_clr)                    r_dropcnt <= '0;
    else if (w_drop && r_dropcnt != 16'hFFFF) r_dropcnt <= r_dropcnt + 16'd1;
  end
`endif

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (bus.address[3:2])
        2'd1: w_rdata = {8'd0, 16'(r_count), 4'd0, w_busy, r_ovf, w_full, w_empty};
`ifdef STREAM_OUT_DROPCNT_EN
        2'd3: w_rdata = {16'd0, r_dropcnt};
`endif
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
endmodule

// File: tb/tb_stream_out_port.sv
module tb_stream_out_port;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_DAT = BASE;
  localparam logic [31:0] A_STA = BASE + 32'd4;
  localparam logic [31:0] A_CTL = BASE + 32'd8;
  localparam logic [31:0] A_CNT = BASE + 32'd12;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stream_out_port_if #(.WIDTH(32)) bus();

  stream_out_port #(.WIDTH(32), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  // Scoreboard: every accepted byte must match the next expected byte.
  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $error("FAIL stream_byte: observed 0x%02h expected no byte", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        assert (bus.out_data === mon_e) n_pass++;
        else $error("FAIL stream_byte: observed 0x%02h expected 0x%02h", bus.out_data, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.address = a;
    bus.wdata   = d;
    bus.enw     = 1'b1;
    tick();
    bus.enw     = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.address = '0;
    bus.wdata = '0;
    bus.enw = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    chk_rd("rst_status", A_STA, 32'h1);
    chk_rd("rst_cnt", A_CNT, 32'h0);
    chk_rd("rd_data_reg", A_DAT, 32'h0);

    // Single word, ready high: latency and byte order
    bus.out_ready = 1'b1;
    push_word(32'h4433_2211);
    wr(A_DAT, 32'h4433_2211);
    check("lat_edge_k", 32'(bus.out_valid), 0);
    tick();
    check("lat_edge_k1", 32'(bus.out_valid), 1);
    check("first_byte", 32'(bus.out_data), 32'h11);
    drain("drain_single", 10);
    tick();
    check("single_idle", 32'(bus.out_valid), 0);
    chk_rd("single_status", A_STA, 32'h1);

    // Outside the window: write ignored, reads 0
    wr(BASE + 32'd16, 32'hDEAD_BEEF);
    tick();
    check("oow_valid", 32'(bus.out_valid), 0);
    chk_rd("oow_status", A_STA, 32'h1);
    chk_rd("oow_read", BASE + 32'd16, 32'h0);

    // Stall: byte held while out_ready low
    bus.out_ready = 1'b0;
    push_word(32'h4433_2211);
    wr(A_DAT, 32'h4433_2211);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_data", 32'(bus.out_data), 32'h11);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("drain_stall", 10);
    tick();
    check("stall_idle", 32'(bus.out_valid), 0);

    // Fill to capacity, then overflow
    bus.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      push_word(32'(i));
      wr(A_DAT, 32'(i));
    end
    chk_rd("full_status", A_STA, (32'(DEPTH) << 8) | 32'hA);
    for (int i = 0; i < 3; i++) wr(A_DAT, 32'h100 + 32'(i));
    chk_rd("ovf_status", A_STA, (32'(DEPTH) << 8) | 32'hE);
`ifdef STREAM_OUT_DROPCNT_EN
    chk_rd("dropcnt3", A_CNT, 32'd3);
`else
    chk_rd("dropcnt_off", A_CNT, 32'd0);
`endif
    bus.out_ready = 1'b1;
    drain("drain_full", 4 * (DEPTH + 1) + 20);
    tick();
    chk_rd("ovf_sticky", A_STA, 32'h5);
    wr(A_CTL, 32'h1);
    chk_rd("ovf_clear", A_STA, 32'h1);
    chk_rd("dropcnt_clr", A_CNT, 32'd0);

    // Back-to-back words: 8 bytes with no bubble
    push_word(32'hA3A2_A1A0);
    push_word(32'hB3B2_B1B0);
    wr(A_DAT, 32'hA3A2_A1A0);
    wr(A_DAT, 32'hB3B2_B1B0);
    for (int i = 0; i < 8; i++) begin
      check("nobubble", 32'(bus.out_valid), 1);
      tick();
    end
    check("b2b_idle", 32'(bus.out_valid), 0);
    check("b2b_empty_q", exp_q.size(), 0);

    // Flush mid-word after two bytes
    push_word(32'hDDCC_BBAA);
    wr(A_DAT, 32'hDDCC_BBAA);
    tick();
    tick();
    tick();
    check("mid_byte", 32'(bus.out_data), 32'hCC);
    bus.out_ready = 1'b0;
    wr(A_CTL, 32'h2);
    exp_q.delete();
    check("flush_valid", 32'(bus.out_valid), 0);
    chk_rd("flush_status", A_STA, 32'h1);
    bus.out_ready = 1'b1;
    push_word(32'h8765_4321);
    wr(A_DAT, 32'h8765_4321);
    drain("drain_after_flush", 10);
    tick();

    // Reset mid-word with three words queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_DAT, 32'hC0 + 32'(i));
    chk_rd("pre_rst_status", A_STA, 32'h0308);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_data", 32'(bus.out_data), 0);
    chk_rd("midrst_status", A_STA, 32'h1);

`ifdef STREAM_OUT_DROPCNT_EN
    for (int i = 0; i < DEPTH + 2; i++) wr(A_DAT, 32'(i));
    chk_rd("dropcnt1", A_CNT, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rd("dropcnt_rst", A_CNT, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
